regfile_dump_tx: RTL

Debug reader for the CPU register file. On a start pulse it walks register indices 0..31 through one register-file read port and serialises every 32-bit value over a UART 8N1 transmit line. A header byte precedes the data. It sits beside the single-cycle datapath so the host can capture architectural state without halting the core.

---
 rtl/regfile_dump_tx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_dump_tx.sv
// -----------------------------------------------------------------------------
// regfile_dump_tx
//
// Debug reader for the CPU register file. On a start pulse it walks register
// indices 0..31 through one register-file read port and serialises every
// 32-bit value over a UART 8N1 transmit line. A header byte goes first, then
// each register as four bytes, most significant byte first. Every register is
// sampled in its own one-cycle LOAD slot, so the core keeps running and
// writes to not-yet-visited registers show up in the frame.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (legal minimum 2)
//   HEADER_BYTE   sync byte sent ahead of the register data
//
// Ports
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   start    in   one-cycle dump request, honoured only while idle
//   rd_addr  out  [4:0]  register index for the register-file read port
//   rd_data  in   [31:0] combinational read data for rd_addr
//   tx       out  UART serial output, idle high
//   busy     out  high while a dump frame is in progress
//   done     out  one-cycle pulse after the final stop bit
// -----------------------------------------------------------------------------
module regfile_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    // Bit slot index on the line: 0 = start, 1..8 = data, 9 = stop.
    localparam logic [3:0] BIT_STOP = 4'd9;
    localparam logic [4:0] IDX_LAST = 5'd31;

    // Top-level states.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic [BAUD_W-1:0] baud_q,     baud_d;
    logic [3:0]        bit_q,      bit_d;
    logic [9:0]        shift_q,    shift_d;     // {stop, data[7:0], start}, LSB on the line
    logic [31:0]       word_q,     word_d;
    logic [1:0]        byte_sel_q, byte_sel_d;
    logic [4:0]        idx_q,      idx_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic baud_tick;
    logic byte_end;

    // Wrap a data byte in its start and stop bits, ready to shift out LSB first.
    function automatic logic [9:0] frame_byte(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Byte sel of a word: sel 3 is bits [31:24], sel 0 is bits [7:0].
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] sel);
        return w[{sel, 3'b000} +: 8];
    endfunction

    assign baud_tick = (baud_q == BAUD_LAST);
    assign byte_end  = baud_tick && (bit_q == BIT_STOP);

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        word_d     = word_q;
        byte_sel_d = byte_sel_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    busy_d  = 1'b1;
                    idx_d   = 5'd0;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                    shift_d = frame_byte(HEADER_BYTE);
                end
            end

            S_HDR, S_SEND: begin
                if (!baud_tick) begin
                    baud_d = baud_q + 1'b1;
                end else begin
                    baud_d = '0;
                    if (!byte_end) begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = {1'b1, shift_q[9:1]};
                    end else begin
                        bit_d = 4'd0;
                        if (state_q == S_HDR) begin
                            state_d = S_LOAD;
                            shift_d = '1;
                        end else if (byte_sel_q != 2'd0) begin
                            // Next byte of the same word follows with no gap.
                            byte_sel_d = byte_sel_q - 2'd1;
                            shift_d    = frame_byte(pick_byte(word_q, byte_sel_q - 2'd1));
                        end else if (idx_q != IDX_LAST) begin
                            idx_d   = idx_q + 5'd1;
                            state_d = S_LOAD;
                            shift_d = '1;
                        end else begin
                            // busy drops as done rises, so the two never overlap.
                            state_d = S_FIN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            shift_d = '1;
                        end
                    end
                end
            end

            S_LOAD: begin
                // rd_addr already shows idx_q; sample the register now and
                // start its MSB byte on the next cycle.
                word_d     = rd_data;
                byte_sel_d = 2'd3;
                shift_d    = frame_byte(rd_data[31:24]);
                baud_d     = '0;
                bit_d      = 4'd0;
                state_d    = S_SEND;
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                shift_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= 4'd0;
            shift_q    <= '1;      // line idles high the moment reset asserts
            word_q     <= '0;
            byte_sel_q <= 2'd0;
            idx_q      <= 5'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every register see the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            byte_sel_q <= byte_sel_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // All outputs come straight from flops: glitch-free on the serial line.
    assign tx      = shift_q[0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_addr = idx_q;

endmodule
